mct_sequencer: RTL and testbench
================================

Name: mct_sequencer

Overview:
- Controller that sequences the timepulse generator (T01–T12 ring, STOP input) by deciding when it runs, stops, single-steps or restarts.
- Timer STOP may only take effect at a memory-cycle (MCT) boundary, marked by the T12 pulse.
- Merges monitor stop/step requests, alarm/start restarts and standby into one registered STOP/GOJAM pair.
- Sits between the monitor/alarm logic and the timer module.

Parameters:
- GOJAM_MCT, 2: number of T12 pulses GOJAM is held after the last restart cause clears.
- SYNC_STAGES, 2: synchroniser depth for the asynchronous inputs MSTP, MSTRTP and SBY.

Ports:
- CLOCK  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- T12  input  1  one-CLOCK pulse at the end of each MCT, from the timer.
- MSTP  input  1  monitor stop level (async).
- MSTRTP  input  1  monitor start/step request (async, edge-used).
- STRT1  input  1  restart cause, synchronous level.
- STRT2  input  1  restart cause, synchronous level.
- ALGA  input  1  restart cause, synchronous one-cycle pulse.
- SBY  input  1  standby request level (async).
- STOP  output  1  hold request to the timer.
- GOJAM  output  1  restart, active-high.
- GOJAM_  output  1  inverse of GOJAM.
- STEPDN  output  1  one-cycle pulse when a single step completes.
- STATE  output  3  current state, for monitor/debug.

Behaviour:
- All outputs are registered.
- A condition sampled in cycle n changes the outputs in cycle n+1.
- MSTP and SBY pass through SYNC_STAGES flops.
- MSTRTP is synchronised, then rising-edge detected into a one-cycle internal pulse STEPREQ.
- State codes: RUN=0, STOPPED=1, STEP=2, RESTART=3, STANDBY=4. Codes 5–7 are illegal and go to RESTART next cycle.
- Reset (async, while rst=1):
  - state=RESTART, count=0, synchroniser flops=0.
  - STOP=0, GOJAM=1, GOJAM_=0, STEPDN=0, STATE=3.
  - Reset is honoured mid-operation from any state.
- RESTCAUSE = STRT1 | STRT2 | ALGA. It is checked first in every state except RESTART, where it only reloads.
  - RESTCAUSE=1 -> RESTART, count=0.
  - Priority order: RESTART, then STANDBY, then monitor stop.
- RUN: STOP=0, GOJAM=0.
  - On T12 with SBY_s=1 -> STANDBY.
  - Else on T12 with MSTP_s=1 -> STOPPED.
  - MSTP or SBY asserting away from T12 waits for the next T12.
- STOPPED: STOP=1.
  - MSTP_s=0 -> RUN.
  - Else STEPREQ=1 -> STEP.
  - SBY_s is ignored while stopped.
- STEP: STOP=0 and the timer runs exactly one MCT.
  - On the first T12 after entry, STEPDN=1 for one cycle.
  - Next state is STOPPED if MSTP_s=1, else RUN.
  - STEPREQ during STEP is dropped (no queueing).
- STANDBY: STOP=1, GOJAM=0.
  - SBY_s=0 -> RESTART, count=0 (leaving standby always generates GOJAM).
- RESTART: GOJAM=1, STOP=0.
  - RESTCAUSE=1 reloads count=0.
  - Else each T12 increments count (width ceil(log2(GOJAM_MCT+1)), saturating).
  - When count reaches GOJAM_MCT -> RUN; GOJAM falls in that same next cycle.
  - If RESTCAUSE and T12 coincide, the reload wins.
  - Monitor and standby are ignored while in RESTART.
  - GOJAM_MCT=0: exit on the first cycle with RESTCAUSE=0.
- GOJAM_ is always the exact complement of GOJAM.
- STATE always equals the current state code.
- T12 arriving in the same cycle as STEPREQ, while in STOPPED, has no effect, since the timer is held.

Test Plan:
- Release rst, keep STRT* low, pulse T12 every 12 cycles.
  -> GOJAM=1 from reset through the 2nd T12; GOJAM=0 and STATE=0 on the cycle after the 2nd T12.
- In RUN, raise MSTP 5 cycles before a T12.
  -> STOP stays 0 until T12; STOP=1 and STATE=1 one cycle after T12 (after SYNC_STAGES settling).
- In STOPPED, pulse MSTRTP (3 cycles wide) twice, 20 cycles apart, with T12 every 12 cycles.
  -> each step gives STOP=0 for one MCT, then a single STEPDN pulse and STOP=1.
  -> Exactly 2 STEPDN pulses; an MSTRTP held high produces no extra steps.
- During STEP, drop MSTP before T12.
  -> STEPDN pulses, then STATE=0 and STOP=0 (continues running).
- In RUN, set SBY=1, hold 30 cycles, then clear it.
  -> STOP=1 and STATE=4 after the next T12.
  -> After release: STATE=3, GOJAM=1 for 2 T12s, then RUN.
- Assert ALGA in STOPPED, and STRT2 in the same cycle as the 2nd restart T12.
  -> ALGA: immediate RESTART (STOP=0, GOJAM=1).
  -> STRT2: count reloads and GOJAM stays high for 2 further T12s.
  -> Assert rst mid-STEP: STOP=0, GOJAM=1, STATE=3 asynchronously.

Source files
------------

// File: rtl/mct_sequencer.sv
// Run/stop/step/restart sequencer for the timepulse generator.
// Merges monitor, alarm and standby requests into registered STOP/GOJAM controls.
module mct_sequencer #(
  parameter int GOJAM_MCT   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       T12,
  input  logic       MSTP,
  input  logic       MSTRTP,
  input  logic       STRT1,
  input  logic       STRT2,
  input  logic       ALGA,
  input  logic       SBY,
  output logic       STOP,
  output logic       GOJAM,
  output logic       GOJAM_,
  output logic       STEPDN,
  output logic [2:0] STATE
);

  localparam int CW = (GOJAM_MCT < 1) ? 1 : $clog2(GOJAM_MCT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(GOJAM_MCT);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_STOPPED = 3'd1,
    S_STEP    = 3'd2,
    S_RESTART = 3'd3,
    S_STANDBY = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                   stop_q, stop_d;
  logic                   gojam_q, gojam_d;
  logic                   gojam_n_q, gojam_n_d;
  logic                   stepdn_q, stepdn_d;
  logic [SYNC_STAGES-1:0] mstp_sync_q, mstp_sync_d;
  logic [SYNC_STAGES-1:0] mstrtp_sync_q, mstrtp_sync_d;
  logic [SYNC_STAGES-1:0] sby_sync_q, sby_sync_d;
  logic                   mstrtp_prev_q, mstrtp_prev_d;
  logic                   mstp_s, mstrtp_s, sby_s;
  logic                   stepreq, restcause;

  assign mstp_sync_d[0]   = MSTP;
  assign mstrtp_sync_d[0] = MSTRTP;
  assign sby_sync_d[0]    = SBY;

  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    assign mstp_sync_d[gi]   = mstp_sync_q[gi-1];
    assign mstrtp_sync_d[gi] = mstrtp_sync_q[gi-1];
    assign sby_sync_d[gi]    = sby_sync_q[gi-1];
  end

  assign mstp_s        = mstp_sync_q[SYNC_STAGES-1];
  assign mstrtp_s      = mstrtp_sync_q[SYNC_STAGES-1];
  assign sby_s         = sby_sync_q[SYNC_STAGES-1];
  assign mstrtp_prev_d = mstrtp_s;
  assign stepreq       = mstrtp_s & ~mstrtp_prev_q;
  assign restcause     = STRT1 | STRT2 | ALGA;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stepdn_d = 1'b0;
    cnt_inc  = (T12 && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

    // A restart cause overrides everything except an ongoing restart, which only reloads.
    if ((state_q != S_RESTART) && restcause) begin
      state_d = S_RESTART;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (T12 && sby_s)       state_d = S_STANDBY;
          else if (T12 && mstp_s) state_d = S_STOPPED;
        end
        S_STOPPED: begin
          if (!mstp_s)      state_d = S_RUN;
          else if (stepreq) state_d = S_STEP;
        end
        S_STEP: begin
          if (T12) begin
            stepdn_d = 1'b1;
            state_d  = mstp_s ? S_STOPPED : S_RUN;
          end
        end
        S_STANDBY: begin
          if (!sby_s) begin
            state_d = S_RESTART;
            cnt_d   = '0;
          end
        end
        S_RESTART: begin
          if (restcause) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_MAX) state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_RESTART;
          cnt_d   = '0;
        end
      endcase
    end

    stop_d    = (state_d == S_STOPPED) || (state_d == S_STANDBY);
    gojam_d   = (state_d == S_RESTART);
    gojam_n_d = ~gojam_d;
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state_q       <= S_RESTART;
      cnt_q         <= '0;
      stop_q        <= 1'b0;
      gojam_q       <= 1'b1;
      gojam_n_q     <= 1'b0;
      stepdn_q      <= 1'b0;
      mstp_sync_q   <= '0;
      mstrtp_sync_q <= '0;
      sby_sync_q    <= '0;
      mstrtp_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stop_q        <= stop_d;
      gojam_q       <= gojam_d;
      gojam_n_q     <= gojam_n_d;
      stepdn_q      <= stepdn_d;
      mstp_sync_q   <= mstp_sync_d;
      mstrtp_sync_q <= mstrtp_sync_d;
      sby_sync_q    <= sby_sync_d;
      mstrtp_prev_q <= mstrtp_prev_d;
    end
  end

  assign STOP   = stop_q;
  assign GOJAM  = gojam_q;
  assign GOJAM_ = gojam_n_q;
  assign STEPDN = stepdn_q;
  assign STATE  = state_q;

endmodule

// File: tb/tb_mct_sequencer.sv
// Bench for mct_sequencer: directed vector table, randomized run against a
// behavioural model, and hand sequences for stepping, standby, restart and reset.
module tb_mct_sequencer;

  localparam int GOJAM_MCT   = 2;
  localparam int SYNC_STAGES = 2;
  localparam int M_RUN = 0, M_STOPPED = 1, M_STEP = 2, M_RESTART = 3, M_STANDBY = 4;

  logic       CLOCK = 1'b0;
  logic       rst = 1'b1;
  logic       T12 = 1'b0, MSTP = 1'b0, MSTRTP = 1'b0;
  logic       STRT1 = 1'b0, STRT2 = 1'b0, ALGA = 1'b0, SBY = 1'b0;
  logic       STOP, GOJAM, GOJAM_, STEPDN;
  logic [2:0] STATE;

  int checks = 0;
  int failures = 0;
  int gcyc = 0;

  always #5 CLOCK = ~CLOCK;

  mct_sequencer #(.GOJAM_MCT(GOJAM_MCT), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CLOCK(CLOCK), .rst(rst), .T12(T12), .MSTP(MSTP), .MSTRTP(MSTRTP),
    .STRT1(STRT1), .STRT2(STRT2), .ALGA(ALGA), .SBY(SBY),
    .STOP(STOP), .GOJAM(GOJAM), .GOJAM_(GOJAM_), .STEPDN(STEPDN), .STATE(STATE)
  );

  // Behavioural model: synchronised inputs are the raw inputs delayed by
  // SYNC_STAGES samples; the restart counter is "T12s seen since the last cause".
  bit mstp_h[$], mstrtp_h[$], sby_h[$];
  bit strtp_prev;
  int m_mode, m_t12s;
  bit m_stepdn;

  task automatic model_reset();
    mstp_h.delete(); mstrtp_h.delete(); sby_h.delete();
    for (int i = 0; i < SYNC_STAGES; i++) begin
      mstp_h.push_back(1'b0); mstrtp_h.push_back(1'b0); sby_h.push_back(1'b0);
    end
    strtp_prev = 1'b0;
    m_mode = M_RESTART;
    m_t12s = 0;
    m_stepdn = 1'b0;
  endtask

  task automatic model_edge(input bit t12, input bit mstp, input bit mstrtp,
                            input bit sby, input bit cause);
    bit m_s, r_s, b_s, req;
    int nxt;
    m_s = mstp_h.pop_front();   mstp_h.push_back(mstp);
    r_s = mstrtp_h.pop_front(); mstrtp_h.push_back(mstrtp);
    b_s = sby_h.pop_front();    sby_h.push_back(sby);
    req = r_s && !strtp_prev;
    strtp_prev = r_s;
    m_stepdn = 1'b0;
    nxt = m_mode;
    if (m_mode == M_RESTART) begin
      if (cause) m_t12s = 0;
      else begin
        if (t12) m_t12s = (m_t12s + 1 > GOJAM_MCT) ? GOJAM_MCT : m_t12s + 1;
        if (m_t12s >= GOJAM_MCT) nxt = M_RUN;
      end
    end else if (cause) begin
      nxt = M_RESTART; m_t12s = 0;
    end else if (m_mode == M_RUN && t12) begin
      nxt = b_s ? M_STANDBY : (m_s ? M_STOPPED : M_RUN);
    end else if (m_mode == M_STOPPED) begin
      nxt = !m_s ? M_RUN : (req ? M_STEP : M_STOPPED);
    end else if (m_mode == M_STEP && t12) begin
      m_stepdn = 1'b1;
      nxt = m_s ? M_STOPPED : M_RUN;
    end else if (m_mode == M_STANDBY && !b_s) begin
      nxt = M_RESTART; m_t12s = 0;
    end
    m_mode = nxt;
  endtask

  function automatic logic [6:0] model_out();
    bit st, gj;
    st = (m_mode == M_STOPPED) || (m_mode == M_STANDBY);
    gj = (m_mode == M_RESTART);
    return {st, gj, ~gj, m_stepdn, 3'(m_mode)};
  endfunction

  function automatic bit t12_at();
    return (gcyc % 12) == 11;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, gcyc);
    end
  endtask

  task automatic do_cycle(input bit t12, input bit mstp, input bit mstrtp, input bit s1,
                          input bit s2, input bit alga, input bit sby, input string tag);
    T12 = t12; MSTP = mstp; MSTRTP = mstrtp; STRT1 = s1; STRT2 = s2; ALGA = alga; SBY = sby;
    @(posedge CLOCK);
    model_edge(t12, mstp, mstrtp, sby, s1 | s2 | alga);
    gcyc++;
    @(negedge CLOCK);
    $display("cyc=%0d %s in t12=%0b mstp=%0b strtp=%0b cause=%0b sby=%0b out stop=%0b gojam=%0b stepdn=%0b state=%0d",
             gcyc, tag, t12, mstp, mstrtp, s1 | s2 | alga, sby, STOP, GOJAM, STEPDN, STATE);
    check({tag, "_model"}, {1'b0, STOP, GOJAM, GOJAM_, STEPDN, STATE}, {1'b0, model_out()});
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_async"}, {4'b0, STOP, GOJAM, GOJAM_, STEPDN}, 8'b0100);
    check({tag, "_state"}, {5'b0, STATE}, 8'd3);
    model_reset();
    @(negedge CLOCK);
    rst = 1'b0;
  endtask

  task automatic run_until(input logic [2:0] target, input bit mstp, input bit mstrtp,
                           input bit sby, input string tag, output int t12s, output int steps);
    t12s = 0; steps = 0;
    for (int i = 0; i < 200 && STATE !== target; i++) begin
      bit t;
      t = t12_at();
      do_cycle(t, mstp, mstrtp, 1'b0, 1'b0, 1'b0, sby, tag);
      if (t) t12s++;
      if (STEPDN) steps++;
    end
    check({tag, "_reach"}, {5'b0, STATE}, {5'b0, target});
  endtask

  typedef struct {
    bit t12, mstp, mstrtp, alga;
    logic [2:0] state;
    bit stop, gojam, stepdn;
  } vec_t;

  vec_t tbl[16];

  initial begin
    bit r_mstp, r_strtp, r_sby, r_s1, r_s2, r_alga;
    int n_t12, n_steps, seen;

    tbl[0]  = '{0, 0, 0, 0, 3'd3, 0, 1, 0};
    tbl[1]  = '{1, 0, 0, 0, 3'd3, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 3'd3, 0, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 3'd0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 3'd0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 3'd0, 0, 0, 0};
    tbl[6]  = '{1, 1, 0, 0, 3'd1, 1, 0, 0};
    tbl[7]  = '{0, 1, 1, 0, 3'd1, 1, 0, 0};
    tbl[8]  = '{0, 1, 1, 0, 3'd1, 1, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 3'd2, 0, 0, 0};
    tbl[10] = '{1, 1, 0, 0, 3'd1, 1, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 3'd1, 1, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 3'd1, 1, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 3'd0, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 1, 3'd3, 0, 1, 0};
    tbl[15] = '{0, 0, 0, 0, 3'd3, 0, 1, 0};

    @(negedge CLOCK);
    do_reset("reset");

    for (int i = 0; i < 16; i++) begin
      do_cycle(tbl[i].t12, tbl[i].mstp, tbl[i].mstrtp, 1'b0, 1'b0, tbl[i].alga, 1'b0, "tbl");
      check($sformatf("tbl_row%0d", i), {1'b0, STOP, GOJAM, GOJAM_, STEPDN, STATE},
            {1'b0, tbl[i].stop, tbl[i].gojam, ~tbl[i].gojam, tbl[i].stepdn, tbl[i].state});
    end

    // Randomized run against the model.
    do_reset("rnd_reset");
    r_mstp = 0; r_strtp = 0; r_sby = 0; r_s1 = 0; r_s2 = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(19) == 0) r_mstp = ~r_mstp;
      if ($urandom_range(59) == 0) r_sby = ~r_sby;
      if ($urandom_range(5) == 0)  r_strtp = ~r_strtp;
      r_s1 = ($urandom_range(199) == 0) ? 1'b1 : (r_s1 && $urandom_range(3) != 0);
      r_s2 = ($urandom_range(199) == 0) ? 1'b1 : (r_s2 && $urandom_range(3) != 0);
      r_alga = ($urandom_range(149) == 0);
      do_cycle(t12_at(), r_mstp, r_strtp, r_s1, r_s2, r_alga, r_sby, "rnd");
    end

    // Two 3-cycle MSTRTP pulses give exactly two steps; a held MSTRTP gives one.
    do_reset("seq_reset");
    run_until(3'd0, 1'b0, 1'b0, 1'b0, "boot", n_t12, n_steps);
    run_until(3'd1, 1'b1, 1'b0, 1'b0, "stop", n_t12, n_steps);
    n_steps = 0;
    for (int i = 0; i < 50; i++) begin
      do_cycle(t12_at(), 1'b1, (i < 3) || (i >= 20 && i < 23), 1'b0, 1'b0, 1'b0, 1'b0, "step2");
      if (STEPDN) n_steps++;
    end
    check("two_steps", 8'(n_steps), 8'd2);
    check("stopped_after_steps", {4'b0, STOP, STATE}, {4'b0, 1'b1, 3'd1});
    n_steps = 0;
    for (int i = 0; i < 50; i++) begin
      do_cycle(t12_at(), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "held");
      if (STEPDN) n_steps++;
    end
    check("held_one_step", 8'(n_steps), 8'd1);

    // Dropping MSTP during a step lets the machine continue running.
    for (int i = 0; i < 3; i++) do_cycle(t12_at(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rel");
    run_until(3'd2, 1'b1, 1'b1, 1'b0, "enter_step", n_t12, n_steps);
    run_until(3'd0, 1'b0, 1'b0, 1'b0, "step_run", n_t12, n_steps);
    check("step_run_stepdn", 8'(n_steps), 8'd1);
    check("step_run_stop", {7'b0, STOP}, 8'd0);

    // Standby entry at T12, exit through a full restart.
    for (int i = 0; i < 30; i++) do_cycle(t12_at(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "sby");
    check("standby", {4'b0, STOP, STATE}, {4'b0, 1'b1, 3'd4});
    run_until(3'd3, 1'b0, 1'b0, 1'b0, "sby_rel", n_t12, n_steps);
    run_until(3'd0, 1'b0, 1'b0, 1'b0, "sby_gojam", n_t12, n_steps);
    check("sby_gojam_t12s", 8'(n_t12), 8'd2);

    // ALGA while stopped, then STRT2 on the second restart T12 reloads the count.
    run_until(3'd1, 1'b1, 1'b0, 1'b0, "stop2", n_t12, n_steps);
    do_cycle(t12_at(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "alga");
    check("alga_restart", {3'b0, STOP, GOJAM, STATE}, {3'b0, 1'b0, 1'b1, 3'd3});
    seen = 0;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      bit t;
      t = t12_at();
      do_cycle(t, 1'b0, 1'b0, 1'b0, t && seen == 1, 1'b0, 1'b0, "strt2");
      if (t) seen++;
    end
    check("strt2_reload_state", {5'b0, STATE}, 8'd3);
    run_until(3'd0, 1'b0, 1'b0, 1'b0, "strt2_exit", n_t12, n_steps);
    check("strt2_t12s", 8'(n_t12), 8'd2);

    // Asynchronous reset in the middle of a step.
    run_until(3'd1, 1'b1, 1'b0, 1'b0, "stop3", n_t12, n_steps);
    run_until(3'd2, 1'b1, 1'b1, 1'b0, "step3", n_t12, n_steps);
    check("pre_rst_step", {5'b0, STATE}, 8'd2);
    #2;
    do_reset("mid_step_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
